// File: rtl/mainmem_pkg.sv
// Shared definitions for the banked main-memory model.
// Contents: default parameter constants and the controller state enum.
package mainmem_pkg;

  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_LATENCY     = 4;
  localparam int DEF_INIT_MODE   = 0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mainmem_array.sv
// Block storage for mainmem_banked.
// Holds DEPTH blocks of DATA_W bits with power-up content selected by
// INIT_MODE, a byte-strobed write port and a registered read port.
// Ports:
//   clk, rst_n   clock, async active-low reset (read register only)
//   i_commit     perform the captured access this cycle
//   i_write      1 = write commit, 0 = read commit
//   i_idx        block index
//   i_wdata      write block
//   i_wstrb      per-byte write enable
//   o_rdata      registered read block (zero after a write commit)
module mainmem_array
  import mainmem_pkg::*;
#(
  parameter int DATA_W      = 8 * DEF_BLOCK_BYTES,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int IDX_W       = 6,
  parameter int DEPTH       = 2 ** IDX_W,
  parameter int INIT_MODE   = DEF_INIT_MODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_commit,
  input  logic                   i_write,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [BLOCK_BYTES-1:0] i_wstrb,
  output logic [DATA_W-1:0]      o_rdata
);

  // Power-up content of one block: zero, or the block index in every byte.
  function automatic logic [DATA_W-1:0] init_block(input int idx);
    logic [7:0] b;
    b = idx[7:0];
    if (INIT_MODE == 1) return {BLOCK_BYTES{b}};
    else                return '0;
  endfunction

  logic [DATA_W-1:0] w_blocks [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  for (genvar g = 0; g < DEPTH; g++) begin : g_blk
    // Initial value applies only at time zero; reset never touches it.
    logic [DATA_W-1:0] r_blk = init_block(g);

    // NOTE: storage has no reset so that rst_n preserves contents and the
    // array can map onto RAM; only control and output registers are reset.
    always_ff @(posedge clk) begin
      if (i_commit && i_write && (i_idx == IDX_W'(g))) begin
        for (int b = 0; b < BLOCK_BYTES; b++) begin
          if (i_wstrb[b]) r_blk[8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end

    assign w_blocks[g] = r_blk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_commit) begin
      r_rdata <= i_write ? '0 : w_blocks[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mainmem_banked.sv
// Fixed-latency block memory with valid/ready request and response.
// One request is in flight at a time: IDLE accepts, ACCESS counts down
// LATENCY cycles and commits, RESP holds the response until consumed.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_write, req_addr              op and byte address (offset ignored)
//   req_wdata, req_wstrb             write block and byte strobes
//   resp_valid/resp_ready            response handshake
//   resp_write, resp_rdata           write ack flag, read block
//   stat_reads, stat_writes          saturating completion counters
module mainmem_banked
  import mainmem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int INIT_MODE   = DEF_INIT_MODE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [8*BLOCK_BYTES-1:0] req_wdata,
  input  logic [BLOCK_BYTES-1:0]   req_wstrb,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_write,
  output logic [8*BLOCK_BYTES-1:0] resp_rdata,
  output logic [15:0]              stat_reads,
  output logic [15:0]              stat_writes
);

  localparam int DATA_W = 8 * BLOCK_BYTES;
  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic                   r_req_ready;
  logic                   r_resp_valid;
  logic                   r_resp_write;
  logic [15:0]            r_stat_reads;
  logic [15:0]            r_stat_writes;
  logic                   r_write;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_W-1:0]      r_wdata;
  logic [BLOCK_BYTES-1:0] r_wstrb;
  logic                   w_commit;
  logic                   w_accept;
  logic                   w_unused_off;

  // Byte offset within a block does not affect the access.
  assign w_unused_off = ^req_addr[OFF_W-1:0];

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_commit = (r_state == ACCESS) && (r_count == '0);

  // NOTE: every clocked block uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_write  <= 1'b0;
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_count     <= CNT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_write <= r_write;
            r_state      <= RESP;
            if (r_write) begin
              if (r_stat_writes != 16'hFFFF) r_stat_writes <= r_stat_writes + 16'd1;
            end else begin
              if (r_stat_reads != 16'hFFFF) r_stat_reads <= r_stat_reads + 16'd1;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_write <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request capture: only sampled on acceptance, so inputs outside IDLE
  // are never looked at. Abandoned captures are harmless after reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_idx   <= req_addr[ADDR_W-1:OFF_W];
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  mainmem_array #(
    .DATA_W      (DATA_W),
    .BLOCK_BYTES (BLOCK_BYTES),
    .IDX_W       (IDX_W),
    .DEPTH       (DEPTH),
    .INIT_MODE   (INIT_MODE)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_commit (w_commit),
    .i_write  (r_write),
    .i_idx    (r_idx),
    .i_wdata  (r_wdata),
    .i_wstrb  (r_wstrb),
    .o_rdata  (resp_rdata)
  );

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_write  = r_resp_write;
  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;

endmodule
